// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO: register map, edge selection codes
// and the synchroniser depth guard.
package pio_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA    = 3'd0,
      ADDR_DIR     = 3'd1,
      ADDR_IRQMASK = 3'd2,
      ADDR_EDGECAP = 3'd3,
      ADDR_OUTSET  = 3'd4,
      ADDR_OUTCLR  = 3'd5,
      ADDR_RSVD6   = 3'd6,
      ADDR_RSVD7   = 3'd7
   } reg_addr_t;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

   // Depths outside the supported range are pulled back to the nearest legal value,
   // which keeps the 3-bit arm counter wide enough for SYNC_STAGES+1.
   function automatic int sync_depth(input int n);
      if (n < SYNC_MIN) return SYNC_MIN;
      if (n > SYNC_MAX) return SYNC_MAX;
      return n;
   endfunction

endpackage

// File: rtl/pio_input_sync.sv
// Pin input synchroniser with previous-value register, edge detector and an
// arm counter that masks events until the chain holds real pin samples.
module pio_input_sync
   import pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] evt
);

   localparam int         STAGES  = sync_depth(SYNC_STAGES);
   localparam logic [2:0] ARM_MAX = 3'(STAGES + 1);

   logic [WIDTH-1:0] chain [STAGES];
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] raw_evt;
   logic [2:0]       arm_cnt;
   logic             armed;

   // NOTE: every stage is reset, not just the output one, so sync_in is a known 0
   // after reset and the arm counter only has to cover the flush time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         prev    <= '0;
         arm_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments make the chain shift one stage per clock
         // regardless of statement order.
         chain[0] <= in_port;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= sync_in;
         if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + 3'd1;
      end
   end

   assign sync_in = chain[STAGES-1];
   assign armed   = (arm_cnt == ARM_MAX);

   // NOTE: raw_evt gets a default before the case so no latch is inferred.
   always_comb begin
      raw_evt = '0;
      case (EDGE_TYPE)
         EDGE_FALLING: raw_evt = ~sync_in & prev;
         EDGE_ANY:     raw_evt = sync_in ^ prev;
         default:      raw_evt = sync_in & ~prev;
      endcase
   end

   assign evt = armed ? raw_evt : '0;

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM PIO: output data with atomic set/clear, per-bit direction,
// synchronised readback, edge capture with write-1-to-clear and a maskable level IRQ.
module avalon_pio_gen2
   import pio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] OUT_RESET   = 32'd0,
   parameter logic [31:0] DIR_RESET   = 32'd0,
   parameter int          EDGE_TYPE   = EDGE_RISING,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] out_en,
   output logic             irq
);

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] rd_val;
   logic             wr;
   reg_addr_t        addr;
   logic             unused_wd;

   assign addr      = reg_addr_t'(address);
   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   pio_input_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .sync_in (sync_in),
      .evt     (evt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= OUT_RESET[WIDTH-1:0];
         dir      <= DIR_RESET[WIDTH-1:0];
         irq_mask <= '0;
      end else if (wr) begin
         case (addr)
            ADDR_DATA:    data_out <= wd;
            ADDR_DIR:     dir      <= wd;
            ADDR_IRQMASK: irq_mask <= wd;
            ADDR_OUTSET:  data_out <= data_out | wd;
            ADDR_OUTCLR:  data_out <= data_out & ~wd;
            default:      ;
         endcase
      end
   end

   // A clear and a fresh event on the same bit resolve in favour of the event.
   assign cap_clr = (wr && addr == ADDR_EDGECAP) ? wd : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edge_cap <= '0;
      else          edge_cap <= (edge_cap & ~cap_clr) | evt;
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         ADDR_DATA:    rd_val = (dir & data_out) | (~dir & sync_in);
         ADDR_DIR:     rd_val = dir;
         ADDR_IRQMASK: rd_val = irq_mask;
         ADDR_EDGECAP: rd_val = edge_cap;
         default:      rd_val = '0;
      endcase
   end

   assign readdata = 32'(rd_val);
   assign out_port = data_out;
   assign out_en   = dir;
   assign irq      = |(edge_cap & irq_mask);

endmodule
